// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the EX stage: signed DIV / unsigned DIVU,
// one quotient bit per cycle, {remainder, quotient} result with a ready pulse.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           div_type_i,
   input  logic [WIDTH-1:0]     op1_i,
   input  logic [WIDTH-1:0]     op2_i,
   input  logic                 annul_i,
   input  logic                 ex_stall_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 stallreq_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [1:0] TYPE_DIV  = 2'b01;
   localparam logic [1:0] TYPE_DIVU = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DZERO = 2'd1,
      S_ON    = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   logic               r_signed;
   logic               r_neg_q;
   logic               r_neg_r;
   logic [WIDTH-1:0]   r_op1;
   logic [WIDTH-1:0]   r_dividend;
   logic [WIDTH-1:0]   r_divisor;
   logic [WIDTH-1:0]   r_rem;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_valid_type;
   logic               w_start;
   logic               w_is_div;
   logic [WIDTH-1:0]   w_abs1;
   logic [WIDTH-1:0]   w_abs2;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_sub;
   logic               w_borrow;
   logic [WIDTH-1:0]   w_rem_nx;
   logic [WIDTH-1:0]   w_quo_nx;
   logic [WIDTH-1:0]   w_rem_fix;
   logic [WIDTH-1:0]   w_quo_fix;

   assign w_valid_type = (div_type_i == TYPE_DIV) || (div_type_i == TYPE_DIVU);
   assign w_start      = (r_state == S_IDLE) && w_valid_type && !annul_i;
   assign w_is_div     = (div_type_i == TYPE_DIV);

   assign stallreq_o = w_start || (r_state == S_ON) || (r_state == S_DZERO);

   // Operand magnitudes; the most negative value maps onto itself, which is the correct unsigned magnitude.
   always_comb begin
      w_abs1 = op1_i;
      w_abs2 = op2_i;
      if (w_is_div && op1_i[WIDTH-1]) begin
         w_abs1 = -op1_i;
      end
      if (w_is_div && op2_i[WIDTH-1]) begin
         w_abs2 = -op2_i;
      end
   end

   // One restoring step: a shifted-out remainder bit means the trial subtraction cannot borrow.
   always_comb begin
      w_rem_sh  = {r_rem, r_dividend[WIDTH-1]};
      w_sub     = w_rem_sh - {1'b0, r_divisor};
      w_borrow  = !w_rem_sh[WIDTH] && w_sub[WIDTH];
      w_rem_nx  = w_borrow ? w_rem_sh[WIDTH-1:0] : w_sub[WIDTH-1:0];
      w_quo_nx  = {r_dividend[WIDTH-2:0], !w_borrow};
      w_quo_fix = (r_signed && r_neg_q) ? -w_quo_nx : w_quo_nx;
      w_rem_fix = (r_signed && r_neg_r) ? -w_rem_nx : w_rem_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_signed   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_op1      <= '0;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_rem      <= '0;
         r_cnt      <= '0;
         result_o   <= '0;
         ready_o    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               ready_o <= 1'b0;
               if (w_start) begin
                  r_signed <= w_is_div;
                  r_op1    <= op1_i;
                  if (op2_i == '0) begin
                     r_state <= S_DZERO;
                  end else begin
                     r_dividend <= w_abs1;
                     r_divisor  <= w_abs2;
                     r_neg_q    <= op1_i[WIDTH-1] ^ op2_i[WIDTH-1];
                     r_neg_r    <= op1_i[WIDTH-1];
                     r_rem      <= '0;
                     r_cnt      <= '0;
                     r_state    <= S_ON;
                  end
               end
            end

            S_ON: begin
               if (annul_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_rem      <= w_rem_nx;
                  r_dividend <= w_quo_nx;
                  r_cnt      <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_LAST) begin
                     result_o <= {w_rem_fix, w_quo_fix};
                     ready_o  <= 1'b1;
                     r_state  <= S_DONE;
                  end
               end
            end

            S_DZERO: begin
               if (annul_i) begin
                  r_state <= S_IDLE;
               end else begin
                  result_o <= {r_op1, {WIDTH{1'b1}}};
                  ready_o  <= 1'b1;
                  r_state  <= S_DONE;
               end
            end

            S_DONE: begin
               // Held while EX is stalled so the result is consumed exactly once.
               if (annul_i || !ex_stall_i) begin
                  ready_o <= 1'b0;
                  r_state <= S_IDLE;
               end
            end

            default: begin
               ready_o <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed and random divides against an arithmetic model,
// plus annul, EX stall hold, mid-operation reset and back-to-back timing.
module tb_div_unit;

   localparam int unsigned W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [1:0]     div_type_i;
   logic [W-1:0]   op1_i;
   logic [W-1:0]   op2_i;
   logic           annul_i;
   logic           ex_stall_i;
   logic [2*W-1:0] result_o;
   logic           ready_o;
   logic           stallreq_o;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   div_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .div_type_i (div_type_i),
      .op1_i      (op1_i),
      .op2_i      (op2_i),
      .annul_i    (annul_i),
      .ex_stall_i (ex_stall_i),
      .result_o   (result_o),
      .ready_o    (ready_o),
      .stallreq_o (stallreq_o)
   );

   // Reference: plain integer division, truncating toward zero, 64-bit to absorb MIN/-1.
   function automatic logic [63:0] ref_div(input logic [1:0] t, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q, r;
      logic [31:0] uq, ur;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (t == 2'b01) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {32'(r), 32'(q)};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   // Present an op for one cycle (S) and return stallreq_o seen in S; leaves bench in S+1.
   task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                        output logic stall_s, output int s_cyc);
      div_type_i = t;
      op1_i      = a;
      op2_i      = b;
      @(negedge clk);
      stall_s = stallreq_o;
      s_cyc   = cyc;
      @(posedge clk);
      #1;
      div_type_i = 2'b00;
   endtask

   // Count cycles after S until ready_o (0 = never within budget); count stall gaps before it.
   task automatic wait_ready(input int budget, output int lat, output int gaps);
      lat  = 0;
      gaps = 0;
      for (int n = 1; n <= budget && lat == 0; n++) begin
         @(negedge clk);
         if (ready_o) lat = n;
         else if (!stallreq_o) gaps++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; div_type_i = 2'b00; op1_i = '0; op2_i = '0;
      annul_i = 1'b0; ex_stall_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (result_o !== 64'd0) $display("FAIL reset_result: got %h want 0", result_o); else passed++;
      total++; if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready_o); else passed++;
      total++; if (stallreq_o !== 1'b0) $display("FAIL reset_stallreq: got %b want 0", stallreq_o); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [1:0]  dt [7];
      logic [31:0] da [7];
      logic [31:0] db [7];
      logic [63:0] de [7];
      logic s0; int sc, lat, gaps, elat;
      dt[0] = 2'b10; da[0] = 32'd100;        db[0] = 32'd7;        de[0] = {32'd2, 32'd14};
      dt[1] = 2'b01; da[1] = 32'hFFFF_FFF9;  db[1] = 32'd2;        de[1] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
      dt[2] = 2'b01; da[2] = 32'd7;          db[2] = 32'hFFFF_FFFE; de[2] = {32'd1, 32'hFFFF_FFFD};
      dt[3] = 2'b01; da[3] = 32'h8000_0000;  db[3] = 32'hFFFF_FFFF; de[3] = {32'd0, 32'h8000_0000};
      dt[4] = 2'b10; da[4] = 32'd5;          db[4] = 32'd0;        de[4] = {32'd5, 32'hFFFF_FFFF};
      dt[5] = 2'b01; da[5] = 32'hFFFF_FFF9;  db[5] = 32'd0;        de[5] = {32'hFFFF_FFF9, 32'hFFFF_FFFF};
      dt[6] = 2'b01; da[6] = 32'hFFFF_FFF8;  db[6] = 32'hFFFF_FFFD; de[6] = {32'hFFFF_FFFE, 32'd2};
      for (int i = 0; i < 7; i++) begin
         elat = (db[i] == 32'd0) ? 2 : 33;
         issue(dt[i], da[i], db[i], s0, sc);
         total++; if (s0 !== 1'b1) $display("FAIL dir%0d_stall_s: got %b want 1", i, s0); else passed++;
         wait_ready(40, lat, gaps);
         total++; if (lat != elat) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, elat); else passed++;
         total++; if (gaps != 0) $display("FAIL dir%0d_stall_gaps: got %0d want 0", i, gaps); else passed++;
         total++; if (stallreq_o !== 1'b0) $display("FAIL dir%0d_stall_at_ready: got %b want 0", i, stallreq_o); else passed++;
         total++; if (result_o !== de[i]) $display("FAIL dir%0d_result: got %h want %h", i, result_o, de[i]); else passed++;
         @(negedge clk);
         total++; if (ready_o !== 1'b0 || result_o !== de[i])
            $display("FAIL dir%0d_idle_hold: got ready=%b res=%h want ready=0 res=%h", i, ready_o, result_o, de[i]);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      logic [1:0] t; logic [31:0] a, b; logic [63:0] exp; logic s0;
      int sc, lat, gaps, elat, mode;
      for (int i = 0; i < 40; i++) begin
         t = 2'($urandom_range(1, 2));
         a = $urandom;
         mode = $urandom_range(0, 9);
         if (mode == 0) b = 32'd0;
         else if (mode == 1) begin b = 32'hFFFF_FFFF; a = 32'h8000_0000; end
         else if (mode <= 4) begin
            b = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) b = -b;
         end
         else b = $urandom;
         exp  = ref_div(t, a, b);
         elat = (b == 32'd0) ? 2 : 33;
         issue(t, a, b, s0, sc);
         wait_ready(40, lat, gaps);
         total++; if (s0 !== 1'b1 || gaps != 0 || lat != elat || stallreq_o !== 1'b0)
            $display("FAIL rnd%0d_timing: got stall_s=%b gaps=%0d lat=%0d sr=%b want 1/0/%0d/0",
                     i, s0, gaps, lat, stallreq_o, elat);
         else passed++;
         total++; if (result_o !== exp)
            $display("FAIL rnd%0d_result t=%0d a=%h b=%h: got %h want %h", i, t, a, b, result_o, exp);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_annul();
      logic s0; logic [63:0] prev; int sc, lat, gaps;
      prev = result_o;
      div_type_i = 2'b10; op1_i = 32'd50; op2_i = 32'd5; annul_i = 1'b1;
      @(negedge clk);
      total++; if (stallreq_o !== 1'b0) $display("FAIL annul_block_stall: got %b want 0", stallreq_o); else passed++;
      @(posedge clk); #1;
      div_type_i = 2'b00; annul_i = 1'b0;
      @(negedge clk);
      total++; if (stallreq_o !== 1'b0) $display("FAIL annul_block_idle: got %b want 0", stallreq_o); else passed++;
      @(posedge clk); #1;
      issue(2'b10, $urandom, 32'($urandom_range(1, 1000)), s0, sc);
      repeat (9) begin @(posedge clk); #1; end
      annul_i = 1'b1;
      @(posedge clk); #1;
      annul_i = 1'b0;
      @(negedge clk);
      total++; if (stallreq_o !== 1'b0 || ready_o !== 1'b0)
         $display("FAIL annul_to_idle: got sr=%b ready=%b want 0/0", stallreq_o, ready_o);
      else passed++;
      wait_ready(40, lat, gaps);
      total++; if (lat != 0) $display("FAIL annul_no_ready: got ready at %0d want never", lat); else passed++;
      total++; if (result_o !== prev) $display("FAIL annul_result_kept: got %h want %h", result_o, prev); else passed++;
      @(posedge clk); #1;
      issue(2'b10, 32'd9, 32'd3, s0, sc);
      wait_ready(40, lat, gaps);
      total++; if (lat != 33 || result_o !== {32'd0, 32'd3})
         $display("FAIL annul_next_op: got lat=%0d res=%h want 33 %h", lat, result_o, {32'd0, 32'd3});
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_ex_stall();
      logic s0; logic [63:0] exp; int sc, lat, gaps;
      exp = ref_div(2'b01, 32'hFFFF_FC18, 32'd7);
      issue(2'b01, 32'hFFFF_FC18, 32'd7, s0, sc);
      wait_ready(40, lat, gaps);
      total++; if (lat != 33 || result_o !== exp)
         $display("FAIL hold_first: got lat=%0d res=%h want 33 %h", lat, result_o, exp);
      else passed++;
      ex_stall_i = 1'b1;
      div_type_i = 2'b10; op1_i = 32'd77; op2_i = 32'd0;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         if (i == 3) begin ex_stall_i = 1'b0; div_type_i = 2'b00; end
         @(negedge clk);
         total++; if (ready_o !== 1'b1 || stallreq_o !== 1'b0 || result_o !== exp)
            $display("FAIL hold_cycle%0d: got ready=%b sr=%b res=%h want 1/0/%h", i, ready_o, stallreq_o, result_o, exp);
         else passed++;
      end
      @(negedge clk);
      total++; if (ready_o !== 1'b0 || stallreq_o !== 1'b0 || result_o !== exp)
         $display("FAIL hold_release: got ready=%b sr=%b res=%h want 0/0/%h", ready_o, stallreq_o, result_o, exp);
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_rst_mid();
      logic s0; int sc, lat, gaps;
      issue(2'b10, 32'd1000, 32'd3, s0, sc);
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++; if (result_o !== 64'd0 || ready_o !== 1'b0 || stallreq_o !== 1'b0)
         $display("FAIL rst_mid_outputs: got res=%h ready=%b sr=%b want 0/0/0", result_o, ready_o, stallreq_o);
      else passed++;
      wait_ready(40, lat, gaps);
      total++; if (lat != 0) $display("FAIL rst_mid_no_ready: got ready at %0d want never", lat); else passed++;
      @(posedge clk); #1;
      issue(2'b10, 32'hFFFF_FFFF, 32'd1, s0, sc);
      wait_ready(40, lat, gaps);
      total++; if (lat != 33 || result_o !== {32'd0, 32'hFFFF_FFFF})
         $display("FAIL rst_fresh_op: got lat=%0d res=%h want 33 %h", lat, result_o, {32'd0, 32'hFFFF_FFFF});
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic s0; logic [63:0] e1, e2; logic [31:0] a1, a2, b1, b2; int sc1, sc2, lat, gaps;
      a1 = $urandom; b1 = $urandom | 32'd1; a2 = $urandom; b2 = 32'($urandom_range(1, 255));
      e1 = ref_div(2'b01, a1, b1);
      e2 = ref_div(2'b10, a2, b2);
      issue(2'b01, a1, b1, s0, sc1);
      wait_ready(40, lat, gaps);
      total++; if (lat != 33 || result_o !== e1)
         $display("FAIL b2b_first: got lat=%0d res=%h want 33 %h", lat, result_o, e1);
      else passed++;
      @(posedge clk); #1;
      issue(2'b10, a2, b2, s0, sc2);
      total++; if (s0 !== 1'b1 || sc2 - sc1 != 34)
         $display("FAIL b2b_second_start: got stall_s=%b gap=%0d want 1 34", s0, sc2 - sc1);
      else passed++;
      wait_ready(40, lat, gaps);
      total++; if (lat != 33 || gaps != 0 || result_o !== e2)
         $display("FAIL b2b_second: got lat=%0d gaps=%0d res=%h want 33 0 %h", lat, gaps, result_o, e2);
      else passed++;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_annul();
      test_ex_stall();
      test_rst_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
